// File: rtl/legv8_bus_interface_unit.sv
// LEGv8 bus interface unit: core load/store -> setup/access/ack bus cycle.
// Optional perf counters under `LEGV8_BUS_PERF_EN.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   cpu_addr/cpu_wdata  core request address / store data (latched on accept)
//   cpu_rd/cpu_wr       core load / store request
//   cpu_rdata           registered load data
//   cpu_stall           core hold (combinational from request in IDLE)
//   cpu_done/cpu_fault  one-cycle completion / fault pulses
//   address             registered external address
//   data                external tri-state data bus
//   mem_oe/mem_we       read / write strobes
//   mem_ack             memory ready
//   perf_xfers/perf_stall  (LEGV8_BUS_PERF_EN only) transfer / stall counters
module legv8_bus_interface_unit #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 32,
    parameter int WAIT_STATES    = 2,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_rd,
    input  logic                  cpu_wr,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    output logic                  cpu_done,
    output logic                  cpu_fault,
    output logic [ADDR_WIDTH-1:0] address,
    inout  wire  [DATA_WIDTH-1:0] data,
    output logic                  mem_oe,
    output logic                  mem_we,
`ifdef LEGV8_BUS_PERF_EN
    output logic [31:0]           perf_xfers,
    output logic [31:0]           perf_stall,
`endif
    input  logic                  mem_ack
);

    // Wide enough for TIMEOUT_CYCLES-1 and WAIT_STATES (< TIMEOUT_CYCLES).
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE,
        FAULT
    } state_t;

    state_t                state;
    logic                  is_wr;
    logic                  drive_en;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [CW-1:0]         wait_cnt;
    logic [CW-1:0]         to_cnt;

    logic req_one;
    logic req_bad;
    logic ack_ok;
    logic to_hit;
    logic wait_full;

    assign req_one   = cpu_rd ^ cpu_wr;
    assign req_bad   = cpu_rd & cpu_wr;
    assign wait_full = (wait_cnt == CW'(WAIT_STATES));
    assign ack_ok    = mem_ack && wait_full;
    assign to_hit    = (to_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Bus is only driven during write SETUP/ACCESS.
    assign data = drive_en ? wdata_q : {DATA_WIDTH{1'bz}};

    // The request term lets the core freeze in the very cycle it asks.
    assign cpu_stall = (state == SETUP)
                     | (state == ACCESS)
                     | ((state == IDLE) & req_one);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            address   <= '0;
            cpu_rdata <= '0;
            wdata_q   <= '0;
            is_wr     <= 1'b0;
            drive_en  <= 1'b0;
            mem_oe    <= 1'b0;
            mem_we    <= 1'b0;
            cpu_done  <= 1'b0;
            cpu_fault <= 1'b0;
            wait_cnt  <= '0;
            to_cnt    <= '0;
        end else begin
            cpu_done  <= 1'b0;
            cpu_fault <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_bad) begin
                        // Ambiguous request: fault without touching the bus.
                        state     <= FAULT;
                        cpu_fault <= 1'b1;
                    end else if (req_one) begin
                        state    <= SETUP;
                        address  <= cpu_addr;
                        wdata_q  <= cpu_wdata;
                        is_wr    <= cpu_wr;
                        drive_en <= cpu_wr;
                    end
                end
                SETUP: begin
                    state    <= ACCESS;
                    mem_oe   <= ~is_wr;
                    mem_we   <= is_wr;
                    wait_cnt <= '0;
                    to_cnt   <= '0;
                end
                ACCESS: begin
                    // Completion is tested first so it wins on the last cycle.
                    if (ack_ok) begin
                        state    <= DONE;
                        cpu_done <= 1'b1;
                        mem_oe   <= 1'b0;
                        mem_we   <= 1'b0;
                        drive_en <= 1'b0;
                        wait_cnt <= '0;
                        to_cnt   <= '0;
                        if (!is_wr) begin
                            cpu_rdata <= data;
                        end
                    end else if (to_hit) begin
                        state     <= FAULT;
                        cpu_fault <= 1'b1;
                        mem_oe    <= 1'b0;
                        mem_we    <= 1'b0;
                        drive_en  <= 1'b0;
                        wait_cnt  <= '0;
                        to_cnt    <= '0;
                    end else begin
                        if (!wait_full) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                FAULT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef LEGV8_BUS_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_xfers <= '0;
            perf_stall <= '0;
        end else begin
            if (state == DONE) begin
                perf_xfers <= perf_xfers + 32'd1;
            end
            if (cpu_stall) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_legv8_bus_interface_unit.sv
// Scoreboard bench for legv8_bus_interface_unit.
// Driver queues expected done/fault pulses; monitor checks them.
`timescale 1ns/1ps
module tb_legv8_bus_interface_unit;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam logic [DW-1:0] PAT = 64'h5A5A_A5A5_5A5A_A5A5;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_rd;
    logic          cpu_wr;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          cpu_done;
    logic          cpu_fault;
    logic [AW-1:0] address;
    wire  [DW-1:0] data;
    logic          mem_oe;
    logic          mem_we;
    logic          mem_ack;
`ifdef LEGV8_BUS_PERF_EN
    logic [31:0]   perf_xfers;
    logic [31:0]   perf_stall;
`endif

    // Memory side: supplies read data under mem_oe, or a probe
    // pattern to show the DUT has released the bus.
    logic          probe;
    logic [DW-1:0] tb_val;
    assign data = (mem_oe || probe) ? tb_val : {DW{1'bz}};

    legv8_bus_interface_unit #(
        .DATA_WIDTH(64),
        .ADDR_WIDTH(32),
        .WAIT_STATES(2),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rd(cpu_rd),
        .cpu_wr(cpu_wr),
        .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .cpu_done(cpu_done),
        .cpu_fault(cpu_fault),
        .address(address),
        .data(data),
        .mem_oe(mem_oe),
        .mem_we(mem_we),
`ifdef LEGV8_BUS_PERF_EN
        .perf_xfers(perf_xfers),
        .perf_stall(perf_stall),
`endif
        .mem_ack(mem_ack)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit            fault;
        logic [DW-1:0] rdata;
        logic [AW-1:0] addr;
        int            cyc;
    } exp_t;

    exp_t          sbq[$];
    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] exp_rdata = '0;
    logic [AW-1:0] exp_addr = '0;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every done/fault pulse must match the head of the queue.
    always @(negedge clock) begin
        exp_t e;
        if (cpu_done || cpu_fault) begin
            if (sbq.size() == 0) begin
                chk("unexpected_pulse", {62'd0, cpu_fault, cpu_done}, '0);
            end else begin
                e = sbq.pop_front();
                chk("pulse_kind", {62'd0, cpu_fault, cpu_done},
                    e.fault ? 64'd2 : 64'd1);
                chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
                chk("pulse_rdata", cpu_rdata, e.rdata);
                chk("pulse_addr", {32'd0, address}, {32'd0, e.addr});
            end
        end
    end

    // One request; end_off is the hand-computed offset of the pulse.
    // mem_ack is high for ACCESS indices ack_lo..ack_hi (ack_lo<0: never).
    task automatic run_xfer(input bit rd, input bit wr,
                            input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            input logic [DW-1:0] rv, input int ack_lo,
                            input int ack_hi, input int end_off,
                            input bit exp_fault);
        int   t0;
        exp_t e;
        bit   legal;
        bit   is_wr;
        legal = rd ^ wr;
        is_wr = wr & ~rd;
        @(posedge clock);
        #1;
        cpu_rd    = rd;
        cpu_wr    = wr;
        cpu_addr  = a;
        cpu_wdata = wd;
        tb_val    = rv;
        probe     = 1'b0;
        t0        = cyc;
        if (legal) exp_addr = a;
        if (legal && !is_wr && !exp_fault) exp_rdata = rv;
        e.fault = exp_fault;
        e.rdata = exp_rdata;
        e.addr  = exp_addr;
        e.cyc   = t0 + end_off;
        sbq.push_back(e);
        for (int off = 0; off <= end_off; off++) begin
            if (off > 0) begin
                @(posedge clock);
                #1;
            end
            mem_ack = (ack_lo >= 0) && (off - 2 >= ack_lo)
                   && (off - 2 <= ack_hi);
            if (off == end_off && is_wr) begin
                probe  = 1'b1;
                tb_val = PAT;
            end
            @(negedge clock);
            chk("mem_oe", {63'd0, mem_oe},
                {63'd0, legal && !is_wr && off >= 2 && off < end_off});
            chk("mem_we", {63'd0, mem_we},
                {63'd0, legal && is_wr && off >= 2 && off < end_off});
            chk("stall", {63'd0, cpu_stall},
                {63'd0, legal && off < end_off});
            if (is_wr && off >= 1 && off < end_off)
                chk("wr_bus", data, wd);
            if (is_wr && off == end_off)
                chk("bus_release", data, PAT);
        end
        cpu_rd  = 1'b0;
        cpu_wr  = 1'b0;
        mem_ack = 1'b0;
        probe   = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        mem_ack   = 1'b0;
        probe     = 1'b1;
        tb_val    = PAT;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_addr", {32'd0, address}, '0);
        chk("rst_rdata", cpu_rdata, '0);
        chk("rst_oe", {63'd0, mem_oe}, '0);
        chk("rst_we", {63'd0, mem_we}, '0);
        chk("rst_done", {63'd0, cpu_done}, '0);
        chk("rst_fault", {63'd0, cpu_fault}, '0);
        chk("rst_stall", {63'd0, cpu_stall}, '0);
        chk("rst_bus", data, PAT);
        reset = 1'b0;
        probe = 1'b0;

        // Read, ack tied high: done at T+5.
        run_xfer(1, 0, 32'h100, '0, 64'hDEADBEEF_CAFEF00D, 0, 99, 5, 0);
        // Write, ack from 5th ACCESS cycle: done at T+7.
        run_xfer(0, 1, 32'h200, 64'h0123456789ABCDEF, '0, 4, 99, 7, 0);
        // Read, no ack: fault at T+10, rdata kept.
        run_xfer(1, 0, 32'h300, '0, 64'h1111_1111_1111_1111, -1, -1, 10, 1);
        // Both strobes: fault at T+1, no bus activity, address kept.
        run_xfer(1, 1, 32'h400, '0, '0, -1, -1, 1, 1);
        // Early single ack (index 1) is ignored: timeout.
        run_xfer(1, 0, 32'h500, '0, 64'h2222_2222_2222_2222, 1, 1, 10, 1);
        // Ack only on the final ACCESS cycle: completion wins.
        run_xfer(1, 0, 32'h600, '0, 64'h0F0E0D0C0B0A0908, 7, 7, 10, 0);
        // Ack only on the first eligible cycle.
        run_xfer(1, 0, 32'h700, '0, 64'h1122334455667788, 2, 2, 5, 0);
        // Back-to-back write with minimum latency.
        run_xfer(0, 1, 32'h800, 64'hFEDCBA9876543210, '0, 0, 99, 5, 0);

        // Reset during ACCESS of a write.
        @(posedge clock);
        #1;
        cpu_wr    = 1'b1;
        cpu_addr  = 32'h900;
        cpu_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
        mem_ack   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("pre_rst_we", {63'd0, mem_we}, 64'd1);
        reset  = 1'b1;
        cpu_wr = 1'b0;
        @(posedge clock);
        #1;
        probe  = 1'b1;
        tb_val = PAT;
        @(negedge clock);
        chk("mid_rst_we", {63'd0, mem_we}, '0);
        chk("mid_rst_oe", {63'd0, mem_oe}, '0);
        chk("mid_rst_addr", {32'd0, address}, '0);
        chk("mid_rst_rdata", cpu_rdata, '0);
        chk("mid_rst_stall", {63'd0, cpu_stall}, '0);
        chk("mid_rst_bus", data, PAT);
        reset     = 1'b0;
        probe     = 1'b0;
        exp_addr  = '0;
        exp_rdata = '0;
        repeat (3) @(posedge clock);

        // Recovery after reset.
        run_xfer(1, 0, 32'hA00, '0, 64'hCAFE_0000_BEEF_1111, 0, 99, 5, 0);

        repeat (4) @(posedge clock);
        chk("sb_empty", 64'(sbq.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
